// File: rtl/hash_jitter_pkg.sv
// Shared types and helpers for the sample-jitter stage: hash width, XOR-fold
// slice count, subsample mask lookup and coordinate selector.
package hash_jitter_pkg;

    localparam int SIGFIG_DEF     = 24;
    localparam int RADIX_DEF      = 10;
    localparam int VERTS_DEF      = 3;
    localparam int AXIS_DEF       = 3;
    localparam int COLORS_DEF     = 3;
    localparam int LANES_DEF      = 4;
    localparam int PIPE_DEPTH_DEF = 2;

    typedef enum logic {
        COORD_X = 1'b0,
        COORD_Y = 1'b1
    } coord_e;

    typedef struct packed {
        logic       one_hot;
        logic [7:0] mask;
    } mask_t;

    // Two fractional bits below the hash are left untouched by the jitter.
    function automatic int hash_width(input int radix);
        return radix - 2;
    endfunction

    function automatic int fold_slices(input int in_w, input int hw);
        return (in_w + hw - 1) / hw;
    endfunction

    function automatic mask_t mask_lookup(input logic [3:0] sub_sample);
        mask_t m;
        m.one_hot = 1'b1;
        m.mask    = 8'hFF;
        case (sub_sample)
            4'b1000: m.mask = 8'hFF;
            4'b0100: m.mask = 8'h7F;
            4'b0010: m.mask = 8'h3F;
            4'b0001: m.mask = 8'h1F;
            default: begin
                m.one_hot = 1'b0;
                m.mask    = 8'hFF;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/hash_jitter_lanes_tree_hash.sv
// tree_hash: zero-pads the operand to a whole number of HW-bit slices, XORs all
// slices together with the seed, then applies the subsample mask.
module tree_hash
    import hash_jitter_pkg::*;
#(
    parameter int IN_W = 40,
    parameter int HW   = 8
) (
    input  logic [IN_W-1:0] data_i,
    input  logic [HW-1:0]   seed_i,
    input  logic [HW-1:0]   mask_i,
    output logic [HW-1:0]   hash_o
);

    localparam int NSLICE = fold_slices(IN_W, HW);
    localparam int PAD_W  = NSLICE * HW;

    logic [PAD_W-1:0] padded;
    logic [HW-1:0]    slice [NSLICE];
    logic [HW-1:0]    fold;

    assign padded = PAD_W'(data_i);

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign slice[gi] = padded[gi*HW +: HW];
        end
    endgenerate

    always_comb begin
        fold = seed_i;
        for (int s = 0; s < NSLICE; s++) begin
            fold = fold ^ slice[s];
        end
    end

    assign hash_o = fold & mask_i;

endmodule

// File: rtl/hash_jitter_lanes.sv
// Stochastic sub-pixel jitter stage with valid/ready backpressure and PIPE_DEPTH
// register stages. Define JITTER_SEED_EN to add the seed_RnnnnU frame-seed port.
module hash_jitter_lanes
    import hash_jitter_pkg::*;
#(
    parameter int SIGFIG     = SIGFIG_DEF,
    parameter int RADIX      = RADIX_DEF,
    parameter int VERTS      = VERTS_DEF,
    parameter int AXIS       = AXIS_DEF,
    parameter int COLORS     = COLORS_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [3:0]                                   subSample_RnnnnU,
`ifdef JITTER_SEED_EN
    input  logic [RADIX-3:0]                             seed_RnnnnU,
`endif
    input  logic                                         in_valid_R14H,
    output logic                                         in_ready_R14H,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    input  logic [COLORS-1:0][SIGFIG-1:0]                color_R14U,
    input  logic signed [1:0][LANES-1:0][SIGFIG-1:0]     sample_R14S,
    input  logic [LANES-1:0]                             validSamp_R14H,
    output logic                                         out_valid_R16H,
    input  logic                                         out_ready_R16H,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    output logic [COLORS-1:0][SIGFIG-1:0]                color_R16U,
    output logic signed [1:0][LANES-1:0][SIGFIG-1:0]     sample_R16S,
    output logic [LANES-1:0]                             validSamp_R16H
);

    localparam int HW   = hash_width(RADIX);
    localparam int SH_W = SIGFIG - 4;

    typedef struct packed {
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_v;
        logic [COLORS-1:0][SIGFIG-1:0]          color;
        logic [1:0][LANES-1:0][SIGFIG-1:0]      sample;
        logic [LANES-1:0]                       valid_samp;
    } beat_t;

    mask_t       mask_info;
    logic [HW-1:0] mask;
    logic [HW-1:0] seed;

    assign mask_info = mask_lookup(subSample_RnnnnU);
    assign mask      = mask_info.one_hot ? HW'(mask_info.mask) : {HW{1'b1}};

`ifdef JITTER_SEED_EN
    assign seed = seed_RnnnnU;
`else
    assign seed = '0;
`endif

    // Jitter is applied to every lane; the per-lane valid only rides along.
    logic [1:0][LANES-1:0][SIGFIG-1:0] jit;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SH_W-1:0] x_sh;
            logic [SH_W-1:0] y_sh;
            logic [HW-1:0]   hash_x;
            logic [HW-1:0]   hash_y;

            assign x_sh = sample_R14S[COORD_X][gi][SIGFIG-1:4];
            assign y_sh = sample_R14S[COORD_Y][gi][SIGFIG-1:4];

            tree_hash #(.IN_W(2*SH_W), .HW(HW)) u_hash_x (
                .data_i ({y_sh, x_sh}),
                .seed_i (seed),
                .mask_i (mask),
                .hash_o (hash_x)
            );

            tree_hash #(.IN_W(2*SH_W), .HW(HW)) u_hash_y (
                .data_i ({x_sh, y_sh}),
                .seed_i (seed),
                .mask_i (mask),
                .hash_o (hash_y)
            );

            assign jit[COORD_X][gi] = sample_R14S[COORD_X][gi] | (SIGFIG'(hash_x) << 2);
            assign jit[COORD_Y][gi] = sample_R14S[COORD_Y][gi] | (SIGFIG'(hash_y) << 2);
        end
    endgenerate

    beat_t beat_in;

    assign beat_in.tri_v      = tri_R14S;
    assign beat_in.color      = color_R14U;
    assign beat_in.sample     = jit;
    assign beat_in.valid_samp = validSamp_R14H;

    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PIPE_DEPTH-1:0] valid_d;
    beat_t                 stage_q [PIPE_DEPTH];
    beat_t                 stage_d [PIPE_DEPTH];
    logic [PIPE_DEPTH:0]   adv;
    logic                  accept;
    logic                  load_in;

    // adv[k]: stage k may load this edge (empty, or its contents move on).
    always_comb begin
        adv             = '0;
        adv[PIPE_DEPTH] = out_ready_R16H;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            adv[k] = !valid_q[k] | adv[k+1];
        end
    end

    assign in_ready_R14H = adv[0] & !rst;
    assign accept        = in_valid_R14H & in_ready_R14H;
    assign load_in       = accept & (|validSamp_R14H);

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        // Beats without a single valid lane are consumed here and become bubbles.
        if (adv[0]) begin
            valid_d[0] = load_in;
            if (load_in) begin
                stage_d[0] = beat_in;
            end
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    stage_d[k] = stage_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid_R16H = valid_q[PIPE_DEPTH-1];
    assign tri_R16S       = stage_q[PIPE_DEPTH-1].tri_v;
    assign color_R16U     = stage_q[PIPE_DEPTH-1].color;
    assign sample_R16S    = stage_q[PIPE_DEPTH-1].sample;
    assign validSamp_R16H = stage_q[PIPE_DEPTH-1].valid_samp;

    a_subsample_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot(subSample_RnnnnU)
    );

endmodule

// File: tb/tb_hash_jitter_lanes.sv
// Self-checking bench for hash_jitter_lanes: directed vectors, backpressure,
// empty-beat drop, mid-flight reset, then randomized traffic against a queue model.
module tb_hash_jitter_lanes;

    localparam int SIGFIG     = 24;
    localparam int RADIX      = 10;
    localparam int HW         = RADIX - 2;
    localparam int VERTS      = 3;
    localparam int AXIS       = 3;
    localparam int COLORS     = 3;
    localparam int LANES      = 4;
    localparam int PIPE_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] ss;
    logic [HW-1:0] seed;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in, tri_o;
    logic [COLORS-1:0][SIGFIG-1:0]          color_in, color_o;
    logic [1:0][LANES-1:0][SIGFIG-1:0]      sample_in, sample_o;
    logic [LANES-1:0]                       vs_in, vs_o;

    always #5 clk = ~clk;

    hash_jitter_lanes #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS),
        .COLORS(COLORS), .LANES(LANES), .PIPE_DEPTH(PIPE_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .subSample_RnnnnU (ss),
`ifdef JITTER_SEED_EN
        .seed_RnnnnU      (seed),
`endif
        .in_valid_R14H    (in_valid),
        .in_ready_R14H    (in_ready),
        .tri_R14S         (tri_in),
        .color_R14U       (color_in),
        .sample_R14S      (sample_in),
        .validSamp_R14H   (vs_in),
        .out_valid_R16H   (out_valid),
        .out_ready_R16H   (out_ready),
        .tri_R16S         (tri_o),
        .color_R16U       (color_o),
        .sample_R16S      (sample_o),
        .validSamp_R16H   (vs_o)
    );

    typedef struct packed {
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_v;
        logic [COLORS-1:0][SIGFIG-1:0]          color;
        logic [1:0][LANES-1:0][SIGFIG-1:0]      sample;
        logic [LANES-1:0]                       vs;
    } beat_t;

    beat_t exp_q[$];
    beat_t exp_b;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hash from the rules: concatenate coordinate integer parts, fold HW bits at a time.
    function automatic logic [HW-1:0] model_hash(input logic [SIGFIG-1:0] lo, input logic [SIGFIG-1:0] hi,
                                                 input logic [3:0] sub, input logic [HW-1:0] sd);
        longint unsigned raw, acc, m;
        raw = (64'(hi >> 4) << (SIGFIG - 4)) | 64'(lo >> 4);
        acc = 64'(sd);
        while (raw != 0) begin
            acc = acc ^ (raw % (64'd1 << HW));
            raw = raw >> HW;
        end
        case (sub)
            4'b1000: m = 64'hFF;
            4'b0100: m = 64'h7F;
            4'b0010: m = 64'h3F;
            4'b0001: m = 64'h1F;
            default: m = 64'hFFFF_FFFF;
        endcase
        return HW'(acc & m);
    endfunction

    function automatic beat_t model_beat();
        beat_t b;
        logic [SIGFIG-1:0] x, y;
        b.tri_v = tri_in;
        b.color = color_in;
        b.vs    = vs_in;
        for (int i = 0; i < LANES; i++) begin
            x = sample_in[0][i];
            y = sample_in[1][i];
            b.sample[0][i] = x | (SIGFIG'(model_hash(x, y, ss, seed)) << 2);
            b.sample[1][i] = y | (SIGFIG'(model_hash(y, x, ss, seed)) << 2);
        end
        return b;
    endfunction

    // Scoreboard: record accepted beats, compare every emitted beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready && (|vs_in)) exp_q.push_back(model_beat());
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_beat", 256'(out_valid), 256'(0));
                end else begin
                    exp_b = exp_q.pop_front();
                    check_eq("out_tri", 256'(tri_o), 256'(exp_b.tri_v));
                    check_eq("out_color", 256'(color_o), 256'(exp_b.color));
                    check_eq("out_sample", 256'(sample_o), 256'(exp_b.sample));
                    check_eq("out_vs", 256'(vs_o), 256'(exp_b.vs));
                end
            end
        end
    end

    task automatic rand_beat(input bit force_valid);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_in[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++) color_in[c] = SIGFIG'($urandom);
        for (int i = 0; i < LANES; i++) begin
            sample_in[0][i] = SIGFIG'($urandom);
            sample_in[1][i] = SIGFIG'($urandom);
        end
        vs_in = LANES'($urandom);
        if (!force_valid && $urandom_range(0, 7) == 0) vs_in = '0;
        if (force_valid && vs_in == '0) vs_in = 1;
        ss = 4'(1 << $urandom_range(0, 3));
`ifdef JITTER_SEED_EN
        seed = HW'($urandom);
`endif
    endtask

    task automatic directed(input logic [SIGFIG-1:0] x, input logic [SIGFIG-1:0] y, input logic [3:0] sub,
                            input logic [HW-1:0] sd, input logic [SIGFIG-1:0] ex,
                            input logic [SIGFIG-1:0] ey, input string tag);
        int lat;
        rand_beat(1'b1);
        for (int i = 0; i < LANES; i++) begin
            sample_in[0][i] = x;
            sample_in[1][i] = y;
        end
        vs_in = '1;
        ss    = sub;
`ifdef JITTER_SEED_EN
        seed  = sd;
`else
        seed  = '0;
        if (sd != '0) $display("note: seed %0h ignored in this build", sd);
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 256'(lat), 256'(PIPE_DEPTH));
        check_eq({tag, "_x"}, 256'(sample_o[0][0]), 256'(ex));
        check_eq({tag, "_y"}, 256'(sample_o[1][0]), 256'(ey));
        check_eq({tag, "_x_lane3"}, 256'(sample_o[0][LANES-1]), 256'(ex));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n_acc, wd, cnt, first, last;
        bit acc0, acc1, acc2, acc, seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ss = 4'b0100; seed = '0;
        tri_in = '0; color_in = '0; sample_in = '0; vs_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 256'(in_ready), 256'(0));
        check_eq("rst_out_valid", 256'(out_valid), 256'(0));
        check_eq("rst_sample", 256'(sample_o), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;

        directed(24'h000400, 24'h000800, 4'b0100, '0, 24'h000520, 24'h000810, "tp_ss4");
        directed(24'h000400, 24'h000800, 4'b0001, '0, 24'h000420, 24'h000810, "tp_ss1");
`ifdef JITTER_SEED_EN
        directed(24'h000400, 24'h000800, 4'b1000, 8'hFF, 24'h0006DC, 24'h0009EC, "tp_seed");
`endif

        // Backpressure: fill with out_ready low, then release.
        out_ready = 1'b0;
        n_acc = 0;
        rand_beat(1'b1);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                rand_beat(1'b1);
            end
        end
        in_valid = 1'b0;
        check_eq("fill_accepts", 256'(n_acc), 256'(2));
        check_eq("full_in_ready", 256'(in_ready), 256'(0));
        out_ready = 1'b1;
        #1;
        check_eq("release_in_ready", 256'(in_ready), 256'(1));
        wd = 0;
        while (exp_q.size() != 0 && wd < 20) begin
            @(posedge clk); #1;
            wd++;
        end
        check_eq("fill_drain", 256'(exp_q.size()), 256'(0));
        repeat (2) @(posedge clk);
        #1;

        // Empty beat between two valid beats, stalled so the bubble collapses.
        out_ready = 1'b0;
        rand_beat(1'b1); in_valid = 1'b1;
        @(negedge clk); acc0 = in_ready;
        @(posedge clk); #1;
        rand_beat(1'b1); vs_in = '0;
        @(negedge clk); acc1 = in_ready;
        @(posedge clk); #1;
        rand_beat(1'b1);
        @(negedge clk); acc2 = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("gap_accepts", 256'(int'(acc0) + int'(acc1) + int'(acc2)), 256'(3));
        out_ready = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            @(posedge clk); #1;
        end
        check_eq("gap_out_count", 256'(cnt), 256'(2));
        check_eq("gap_back_to_back", 256'(last - first), 256'(1));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        rand_beat(1'b1); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_beat(1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_out_valid", 256'(out_valid), 256'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("rst_mid_no_output", 256'(seen), 256'(0));

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            rand_beat(1'b0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wd = 0;
        while (exp_q.size() != 0 && wd < 20) begin
            @(posedge clk); #1;
            wd++;
        end
        check_eq("final_drain", 256'(exp_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_jitter_lanes.md
# hash_jitter_lanes

Parameterised stochastic-jitter stage sitting between sample generation (R14) and the sample test (R16+N) in the raster pipeline. For each of LANES sample positions it computes an XOR-fold hash of the sample coordinates, masks it according to the subsample rate, and ORs it into the sub-pixel bits of the sample. Triangle and colour ride alongside. Unlike the fixed-latency predecessor, it carries a valid/ready handshake with per-stage backpressure, drops beats with no valid lanes, and has configurable lane count and depth.

## Interface
- SIGFIG, 24, fixed-point word width
- RADIX, 10, fractional bits; hash width HW = RADIX-2
- VERTS, 3, triangle vertices
- AXIS, 3, coordinates per vertex
- COLORS, 3, colour channels
- LANES, 4, parallel samples per beat (≥1)
- PIPE_DEPTH, 2, register stages (≥1)

- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- subSample_RnnnnU  in  4  one-hot subsample rate, quasi-static
- in_valid_R14H  in  1  input beat valid
- in_ready_R14H  out  1  stage can accept
- tri_R14S  in  [VERTS][AXIS]×SIGFIG signed  triangle
- color_R14U  in  [COLORS]×SIGFIG  colour
- sample_R14S  in  [2][LANES]×SIGFIG signed  sample x/y per lane
- validSamp_R14H  in  [LANES]×1  per-lane valid
- out_valid_R16H  out  1  output beat valid
- out_ready_R16H  in  1  downstream accepts
- tri_R16S, color_R16U, sample_R16S, validSamp_R16H  out  same shapes as inputs, jittered samples
- seed_RnnnnU  in  HW  frame seed (only with JITTER_SEED_EN)

## Operation
- Mask from subSample: bit3→0xFF, bit2→0x7F, bit1→0x3F, bit0→0x1F (truncated to HW bits). Non-one-hot: assertion fires; mask = all ones.
- X hash, lane i: H = {y[SIGFIG-1:4], x[SIGFIG-1:4]} (2·(SIGFIG-4) bits); zero-pad at MSB to a multiple of HW; XOR all HW-bit slices; result & mask. Y hash: same with operand order {x, y}.
- Jittered coord = coord | (hash zero-extended, shifted left by 2). Applied to every lane; lanes with validSamp=0 carry their value through but validSamp stays 0.
- Beat accepted when in_valid & in_ready. Accepted beat with all validSamp lanes 0 is consumed and not propagated (no output beat).
- Pipeline: PIPE_DEPTH stages, each with a valid bit. Stage k loads when it is empty or its contents move on the same edge; the last stage moves when out_ready. Bubbles collapse. in_ready = !v0 | stage0 moves (combinational from out_ready through the valid chain).
- out_valid_R16H = valid bit of last stage; outputs held stable while out_valid & !out_ready.
- Hash computed combinationally before stage 0; all later stages are plain data registers.

## Timing
- Latency PIPE_DEPTH cycles from accept to out_valid with no stall; throughput 1 beat/cycle under continuous out_ready.
- Reset: all stage valid bits and all output data registers → 0; out_valid_R16H = 0; in_ready_R14H = 0 while rst high, 1 the cycle after.
- Reset mid-operation: in-flight beats discarded, none emitted after rst deasserts.
- Full pipeline, out_ready=0: in_ready=0; no beat lost or duplicated. Out_ready reasserts → in_ready = 1 same cycle.
- Simultaneous accept and emit when full: legal, occupancy unchanged.
- subSample change takes effect on beats accepted from that cycle on.

## Configuration
- JITTER_SEED_EN defined: seed_RnnnnU port present; seed XORed into each raw hash before masking; sampled at accept.
- Undefined: no seed port; behaviour identical to seed = 0.

## Structure
- Shared package hash_jitter_pkg: HW localparam derivation, mask-lookup function, lane/struct typedefs for the beat payload.
- One sub-module: existing tree_hash (XOR fold + mask), instantiated 2·LANES times via generate.

## Test plan
- x=0x000400, y=0x000800, subSample=4'b0100, LANES=4 identical -> every lane x=0x000520, y=0x000810 after 2 cycles.
- Same sample, subSample=4'b0001 -> hash X 0x48&0x1F=0x08, x=0x000420; Y 0x84&0x1F=0x04, y=0x000810.
- Fill pipeline with out_ready=0 for 5 cycles -> in_ready low after 2 accepts, release gives both beats in order, none dropped.
- Beat with validSamp=4'b0000 between two valid beats -> only two output beats, back-to-back.
- Assert rst with 2 beats in flight -> out_valid 0 next cycle, no later output.
- JITTER_SEED_EN, seed=0xFF, first vector, subSample=4'b1000 -> x hash 0xB7, x=0x0006DC.
